// File: rtl/full_adder.sv
// 1-bit full adder with a per-net switching-activity monitor.
// The datapath is purely combinational; the clocked side only counts toggles for power estimation.
module full_adder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             clr,
    output logic             sum,
    output logic             carry,
    output logic [CNT_W-1:0] tgl_a,
    output logic [CNT_W-1:0] tgl_b,
    output logic [CNT_W-1:0] tgl_c,
    output logic [CNT_W-1:0] tgl_sum,
    output logic [CNT_W-1:0] tgl_carry,
    output logic [CNT_W+2:0] tgl_total,
    output logic [CNT_W-1:0] sample_cnt
);

    localparam int unsigned NumNets = 5;
    localparam logic [CNT_W-1:0] CntMax = '1;

    // Net order in every vector below: a, b, c, sum, carry.
    logic [NumNets-1:0] cur;
    logic [NumNets-1:0] prev_q, prev_d;
    logic               base_q, base_d;
    logic [CNT_W-1:0]   cnt_q [NumNets];
    logic [CNT_W-1:0]   cnt_d [NumNets];
    logic [CNT_W-1:0]   sample_q, sample_d;

    // Datapath: independent of clk, rst and clr.
    always_comb begin
        sum   = a ^ b ^ c;
        carry = (a & b) | (a & c) | (b & c);
    end

    always_comb begin
        cur = {a, b, c, sum, carry};
    end

    always_comb begin
        prev_d   = cur;
        base_d   = base_q;
        sample_d = sample_q;
        for (int i = 0; i < NumNets; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (clr) begin
            // Baseline survives a clear so the very next edge already counts.
            sample_d = '0;
            for (int i = 0; i < NumNets; i++) begin
                cnt_d[i] = '0;
            end
        end else begin
            if (!base_q) begin
                base_d = 1'b1;
            end else begin
                for (int i = 0; i < NumNets; i++) begin
                    if ((cur[i] != prev_q[i]) && (cnt_q[i] != CntMax)) begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
            end
            if (sample_q != CntMax) begin
                sample_d = sample_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q   <= '0;
            base_q   <= 1'b0;
            sample_q <= '0;
            for (int i = 0; i < NumNets; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            prev_q   <= prev_d;
            base_q   <= base_d;
            sample_q <= sample_d;
            for (int i = 0; i < NumNets; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // cur/prev bit 4 is a, bit 0 is carry; counters use the same index mapping.
    always_comb begin
        tgl_a      = cnt_q[4];
        tgl_b      = cnt_q[3];
        tgl_c      = cnt_q[2];
        tgl_sum    = cnt_q[1];
        tgl_carry  = cnt_q[0];
        sample_cnt = sample_q;
    end

    always_comb begin
        tgl_total = '0;
        for (int i = 0; i < NumNets; i++) begin
            tgl_total = tgl_total + {3'b000, cnt_q[i]};
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder: truth table, reset, toggle counting, clear, saturation.
module tb_full_adder;

    logic clk, rst, clr, a, b, c;
    logic sum, carry, sum2, carry2;
    logic [15:0] tgl_a, tgl_b, tgl_c, tgl_sum, tgl_carry, sample_cnt;
    logic [18:0] tgl_total;
    logic [1:0]  s_a, s_b, s_c, s_sum, s_carry, s_sample;
    logic [4:0]  s_total;

    int n_cmp = 0;
    int n_bad = 0;

    full_adder #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .clr(clr),
        .sum(sum), .carry(carry),
        .tgl_a(tgl_a), .tgl_b(tgl_b), .tgl_c(tgl_c), .tgl_sum(tgl_sum),
        .tgl_carry(tgl_carry), .tgl_total(tgl_total), .sample_cnt(sample_cnt)
    );

    full_adder #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .clr(clr),
        .sum(sum2), .carry(carry2),
        .tgl_a(s_a), .tgl_b(s_b), .tgl_c(s_c), .tgl_sum(s_sum),
        .tgl_carry(s_carry), .tgl_total(s_total), .sample_cnt(s_sample)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setv(input logic [2:0] v);
        {a, b, c} = v;
    endtask

    task automatic check_counts(input string name, input int ea, input int eb, input int ec,
                                input int es, input int ecy, input int esmp);
        int etot;
        etot = ea + eb + ec + es + ecy;
        n_cmp++;
        if (tgl_a !== 16'(ea) || tgl_b !== 16'(eb) || tgl_c !== 16'(ec) ||
            tgl_sum !== 16'(es) || tgl_carry !== 16'(ecy) || tgl_total !== 19'(etot) ||
            sample_cnt !== 16'(esmp)) begin
            n_bad++;
            $display("FAIL %s: got a=%0d b=%0d c=%0d sum=%0d carry=%0d total=%0d smp=%0d, want %0d %0d %0d %0d %0d %0d %0d",
                     name, tgl_a, tgl_b, tgl_c, tgl_sum, tgl_carry, tgl_total, sample_cnt,
                     ea, eb, ec, es, ecy, etot, esmp);
        end
    endtask

    task automatic test_truth_table();
        logic [2:0] v;
        int s;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            setv(v);
            #1;
            s = int'(v[2]) + int'(v[1]) + int'(v[0]);
            n_cmp++;
            if (sum !== s[0] || carry !== s[1] || sum2 !== s[0] || carry2 !== s[1]) begin
                n_bad++;
                $display("FAIL truth_%0b: got sum=%b carry=%b, want sum=%b carry=%b",
                         v, sum, carry, s[0], s[1]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clr = 1'b0;
        setv(3'b011);
        tick();
        setv(3'b111);
        tick();
        check_counts("reset", 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (sum !== 1'b1 || carry !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_comb: got sum=%b carry=%b, want 1 1", sum, carry);
        end
        setv(3'b010);
        #1;
        n_cmp++;
        if (sum !== 1'b1 || carry !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_comb2: got sum=%b carry=%b, want 1 0", sum, carry);
        end
    endtask

    task automatic test_activity();
        // Vectors 010,011,010,111,000: c 0,1,0,1,0; sum 1,0,1,1,0; carry 0,1,0,1,0.
        rst = 1'b0;
        setv(3'b010); tick();
        check_counts("baseline_edge", 0, 0, 0, 0, 0, 1);
        setv(3'b011); tick();
        check_counts("act_011", 0, 0, 1, 1, 1, 2);
        setv(3'b010); tick();
        setv(3'b111); tick();
        check_counts("act_111", 1, 0, 3, 2, 3, 4);
        setv(3'b000); tick();
        check_counts("act_final", 2, 1, 4, 3, 4, 5);
    endtask

    task automatic test_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_counts("clear", 0, 0, 0, 0, 0, 0);
        setv(3'b001); tick();
        check_counts("after_clear", 0, 0, 1, 1, 0, 1);
    endtask

    task automatic test_rst_clr();
        setv(3'b110); tick();
        check_counts("pre_rst", 1, 1, 2, 2, 1, 2);
        rst = 1'b1;
        clr = 1'b1;
        setv(3'b111);
        tick();
        rst = 1'b0;
        clr = 1'b0;
        check_counts("rst_clr", 0, 0, 0, 0, 0, 0);
        setv(3'b000); tick();
        check_counts("rebaseline", 0, 0, 0, 0, 0, 1);
        setv(3'b100); tick();
        check_counts("after_rebase", 1, 0, 0, 1, 0, 2);
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        setv(3'b000);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a = ~a;
            tick();
        end
        n_cmp++;
        if (s_a !== 2'd3 || s_sample !== 2'd3 || s_b !== 2'd0 || s_sum !== 2'd3 ||
            s_total !== 5'd6) begin
            n_bad++;
            $display("FAIL sat_small: got a=%0d smp=%0d b=%0d sum=%0d total=%0d, want 3 3 0 3 6",
                     s_a, s_sample, s_b, s_sum, s_total);
        end
        check_counts("sat_wide", 5, 0, 0, 5, 0, 6);
        for (int i = 0; i < 2; i++) begin
            a = ~a;
            tick();
        end
        n_cmp++;
        if (s_a !== 2'd3 || s_sample !== 2'd3) begin
            n_bad++;
            $display("FAIL sat_hold: got a=%0d smp=%0d, want 3 3", s_a, s_sample);
        end
    endtask

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        setv(3'b000);
        test_truth_table();
        test_reset();
        test_activity();
        test_clear();
        test_rst_clr();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
